// File: rtl/nibble_serial_alu_ctrl_if.sv
// Handshake, operand/result and adder-slice signals of the nibble-serial ALU sequencer.
// The slave side is the sequencer; the master side is the datapath control plus the adder slice.
interface nibble_serial_alu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             opSub;
  logic [WIDTH-1:0] aIn;
  logic [WIDTH-1:0] bIn;
  logic [3:0]       addA;
  logic [3:0]       addB;
  logic             addCin;
  logic [3:0]       addSum;
  logic             addCout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryOut;
  logic             overflow;
  logic             zero;

  modport slave (
    input  start, opSub, aIn, bIn, addSum, addCout,
    output addA, addB, addCin, busy, done, result, carryOut, overflow, zero
  );

  modport master (
    output start, opSub, aIn, bIn, addSum, addCout,
    input  addA, addB, addCin, busy, done, result, carryOut, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequences WIDTH-bit add/subtract through one external 4-bit adder slice, LSB nibble first,
// with a start/busy/done handshake and registered carry/overflow/zero flags.
module nibble_serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  nibble_serial_alu_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [CNT_W+1:0] nib_lsb;

  // b is already inverted for subtract, so equal MSBs mean same-sign addends.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  assign nib_lsb = {cnt_q, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    bus.addA   = 4'h0;
    bus.addB   = 4'h0;
    bus.addCin = 1'b0;

    unique case (state_q)
      S_RUN: begin
        bus.addA   = a_q[nib_lsb +: 4];
        bus.addB   = b_q[nib_lsb +: 4];
        bus.addCin = carry_q;
        result_d[nib_lsb +: 4] = bus.addSum;
        carry_d    = bus.addCout;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_NIB) begin
          state_d = S_DONE;
          cout_d  = bus.addCout;
          ovf_d   = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], result_d[WIDTH-1]);
          zero_d  = (result_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A start in IDLE or DONE wins over the default IDLE transition.
    if (bus.start && (state_q != S_RUN)) begin
      state_d  = S_RUN;
      a_d      = bus.aIn;
      b_d      = bus.opSub ? ~bus.bIn : bus.bIn;
      carry_d  = bus.opSub;
      cnt_d    = '0;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      zero_d   = 1'b0;
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.carryOut = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Scoreboard bench: a behavioural 4-bit adder slice plus randomized and directed operations.
module tb_nibble_serial_alu_ctrl;
  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  nibble_serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External ripple adder slice, combinational return path.
  assign {bus.addCout, bus.addSum} = 5'(bus.addA) + 5'(bus.addB) + 5'(bus.addCin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, s;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op) begin
      e.r = a - b;
      e.c = (ua >= ub);
      s   = sa - sb;
    end else begin
      e.r = a + b;
      e.c = ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
      s   = sa + sb;
    end
    e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.z   = (e.r == 32'h0);
    e.due = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // All stimulus steps land 1 time unit after a rising edge.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   guard = 0;
    while (bus.busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy still high after %0d cycles", guard);
    end
    bus.start = 1'b1;
    bus.opSub = op;
    bus.aIn   = a;
    bus.bIn   = b;
    e     = ref_op(op, a, b);
    e.due = cyc + NIB + 1;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.opSub = 1'($urandom);
    bus.aIn   = $urandom;
    bus.bIn   = $urandom;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sbq.size() != 0 || bus.busy || bus.done) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sbq.size() != 0 || bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending=%0d busy=%0b, expected 0 and 0", sbq.size(), bus.busy);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no outstanding operation (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("result",   64'(bus.result),   64'(e.r));
        chk("carryOut", 64'(bus.carryOut), 64'(e.c));
        chk("overflow", 64'(bus.overflow), 64'(e.v));
        chk("zero",     64'(bus.zero),     64'(e.z));
        chk("latency",  64'(cyc),          64'(e.due));
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.opSub = 1'b0;
    bus.aIn   = '0;
    bus.bIn   = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_done",     64'(bus.done),     64'd0);
    chk("rst_result",   64'(bus.result),   64'd0);
    chk("rst_flags",    64'({bus.carryOut, bus.overflow, bus.zero}), 64'd0);
    chk("rst_adder_in", 64'({bus.addA, bus.addB, bus.addCin}),       64'd0);

    issue(1'b0, 32'h0000_000F, 32'h0000_0001);
    for (int i = 0; i < NIB; i++) begin
      chk("busy_run", 64'(bus.busy), 64'd1);
      @(posedge clk); #1;
    end
    chk("busy_after_run", 64'(bus.busy), 64'd0);
    chk("done_after_run", 64'(bus.done), 64'd1);
    wait_idle();
    chk("idle_adder_in", 64'({bus.addA, bus.addB, bus.addCin}), 64'd0);

    // Back-to-back issues land in the DONE cycle of the previous operation.
    issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(1'b1, 32'h0000_0005, 32'h0000_0005);
    issue(1'b1, 32'h0000_0003, 32'h0000_0005);
    wait_idle();

    issue(1'b0, 32'h1234_5678, 32'h1111_1111);
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.opSub = 1'b1;
    bus.aIn   = 32'hDEAD_BEEF;
    bus.bIn   = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("result_held", 64'(bus.result), 64'h2345_6789);

    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    chk("abort_busy",   64'(bus.busy),   64'd0);
    chk("abort_done",   64'(bus.done),   64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    reset = 1'b0;
    repeat (NIB + 2) begin @(posedge clk); #1; end
    chk("abort_no_done", 64'(bus.done), 64'd0);
    issue(1'b0, 32'h0000_000F, 32'h0000_0001);
    wait_idle();

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(1'($urandom), pick(), pick());
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_alu_ctrl.md
Name: nibble_serial_alu_ctrl

Overview:
- Sequencer that time-shares one external 4-bit ripple adder slice (a, b, carry-in in; sum, carry-out back) to perform WIDTH-bit add/subtract, one nibble per cycle, LSB nibble first.
- Serves the area-reduced ALU option of the MIPS datapath.
- Provides a start/busy/done handshake toward the datapath control unit, plus result flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and ≥ 8.
- NIBBLES, WIDTH/4, number of adder passes per operation (derived; not overridden independently).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- opSub  input  1  0 = A+B, 1 = A−B; sampled with start.
- aIn  input  WIDTH  operand A; sampled with start.
- bIn  input  WIDTH  operand B; sampled with start.
- addA  output  4  nibble of A to adder slice.
- addB  output  4  nibble of effective B to adder slice.
- addCin  output  1  carry into adder slice.
- addSum  input  4  sum from adder slice (combinational return, same cycle).
- addCout  input  1  carry-out from adder slice (same cycle).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, result valid.
- result  output  WIDTH  A±B, held until the next accepted start.
- carryOut  output  1  final carry-out (for subtract, 1 = no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-operation):
  - State goes to IDLE.
  - busy, done, result, carryOut, overflow, zero are all 0.
  - Internal operand registers, carry register and nibble counter are cleared.
- States: IDLE, RUN, DONE.
- Accept rule: start=1 while in IDLE or DONE (busy=0) at edge E0:
  - Latch aReg=aIn and bReg = opSub ? ~bIn : bIn.
  - Set carryReg=opSub, cnt=0, result=0; go to RUN.
  - start while busy=1 is ignored; operands are not re-sampled.
- RUN, cycle i (between edges E(i) and E(i+1)), for i = 0..NIBBLES−1:
  - Drive addA=aReg[4i+3:4i], addB=bReg[4i+3:4i], addCin=carryReg.
  - At E(i+1): result[4i+3:4i] <= addSum, carryReg <= addCout, cnt <= cnt+1.
  - The last RUN cycle (cnt==NIBBLES−1) transitions to DONE at edge E(NIBBLES).
  - Only nibble i of result changes in each RUN cycle; the other bits keep their values.
- Outside RUN, addA, addB and addCin are driven 0.
- busy=1 exactly in RUN, i.e. for NIBBLES cycles (E0 through E(NIBBLES)).
- DONE lasts exactly one cycle:
  - done=1 and the final values are valid in that cycle.
  - Next state is RUN if start=1, else IDLE.
- Latency: done is high in the cycle after edge E(NIBBLES). Throughput is one operation per NIBBLES+1 cycles (back-to-back start issued in DONE).
- Flags, registered at E(NIBBLES) and held until the next accept (cleared at accept):
  - carryOut = final addCout.
  - overflow = (aReg[MSB]==bReg[MSB]) && (result[MSB]!=aReg[MSB]).
  - zero = (final result == 0).
- Arithmetic is modulo 2^WIDTH; carries beyond the MSB are dropped except into carryOut.
- Because the adder return path is combinational, the adder slice must settle within one clk period.

Test Plan (WIDTH=32, external 4-bit ripple adder slice attached):
- Reset held 2 cycles, then released → busy=0, done=0, result=0, all flags 0, addA=addB=addCin=0.
- start, opSub=0, A=0x0000_000F, B=0x0000_0001 → busy high for 8 cycles, done pulse in cycle 9; result=0x0000_0010, carryOut=0, overflow=0, zero=0; the carry ripples across the nibble 0→1 boundary.
- start, opSub=0, A=0x7FFF_FFFF, B=0x0000_0001 → result=0x8000_0000, overflow=1, carryOut=0. Then A=0xFFFF_FFFF, B=0x0000_0001 → result=0, carryOut=1, zero=1, overflow=0.
- start, opSub=1, A=5, B=5 → result=0, zero=1, carryOut=1. Then A=3, B=5 → result=0xFFFF_FFFE, carryOut=0, overflow=0.
- Second start pulsed mid-RUN with different operands → ignored, first result unchanged. A start issued in the DONE cycle is accepted: the next done arrives exactly 9 cycles later.
- reset asserted in RUN cycle 4 → next cycle IDLE with busy=0, result=0, no done pulse. A subsequent start computes correctly, with no carry left over from the aborted operation.
